serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request to add; it is sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: the operands, captured on the accepting edge.
REQ-006 The block SHALL have port cin, input, 1 bit: the carry-in, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse, high while in DONE.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the registered result, held until the next DONE.
REQ-010 The block SHALL have port cout, output, 1 bit: the registered carry-out, held until the next DONE.

Function
REQ-011 The FSM SHALL have the states IDLE, RUN and DONE; IDLE is the reset state.
REQ-012 In IDLE with start=1 at edge E0, the block SHALL load a_sr=a, b_sr=b, carry=cin and cnt=0, and enter RUN.
REQ-013 On each RUN edge, a 1-bit full-adder cell SHALL combine a_sr[0], b_sr[0] and carry; the cell's sum bit shifts into res_sr at the MSB (right shift), carry takes the cell's carry-out, a_sr and b_sr shift right, and cnt increments.
REQ-014 Operands SHALL be processed LSB-first; after WIDTH RUN edges, res_sr holds a+b+cin modulo 2^WIDTH.
REQ-015 On the RUN edge where cnt==WIDTH-1 (edge E_WIDTH), the block SHALL update sum with the final res_sr, set cout to the final carry, and enter DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE; done is high only in DONE.
REQ-017 The latency SHALL be fixed: done is high in the cycle after edge E_WIDTH, independent of the operand values.
REQ-018 start SHALL be ignored in RUN and DONE, with no queuing; a start held high continuously SHALL be re-accepted at the first IDLE edge.
REQ-019 Changes on a, b and cin after E0 SHALL NOT affect the operation in flight.
REQ-020 sum and cout SHALL change only on the edge entering DONE, and SHALL otherwise hold their previous values.
REQ-021 cnt SHALL be $clog2(WIDTH)+1 bits wide, and SHALL never wrap during a legal operation.

Reset
REQ-022 When rst_n=0, the block SHALL immediately force the state to IDLE, and busy, done, sum, cout, carry, cnt, a_sr, b_sr and res_sr to 0, regardless of clk.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced for it, and sum and cout read 0.
REQ-024 After rst_n rises, the first start SHALL be accepted at the first rising edge where start=1.

Structure
REQ-025 A shared package serial_adder_pkg SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-026 One sub-module SHALL be instantiated: fa_bit, a combinational 1-bit full adder with inputs a, b, ci and outputs s, co; the carry register SHALL live in serial_adder.
REQ-027 No other sub-modules SHALL be used; the FSM, counter and shift registers are inline.

Verification
REQ-028 With WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start pulsed, the bench SHALL check sum=8'h96, cout=0, and done high exactly in the cycle after the 8th RUN edge.
REQ-029 With a=8'hFF, b=8'h01, cin=0, the bench SHALL check sum=8'h00, cout=1; with a=8'hFF, b=8'hFF, cin=1, it SHALL check sum=8'hFF, cout=1.
REQ-030 With start held high for 20 cycles, the bench SHALL check exactly two accepted operations, with done pulses 10 cycles apart and busy low in each DONE cycle.
REQ-031 With rst_n pulled low after the 4th RUN edge, the bench SHALL check that busy, done, sum and cout drop to 0 immediately, no done pulse follows, and a subsequent start with 8'h01+8'h01 gives sum=8'h02.
REQ-032 When a and b are changed every cycle during RUN, the bench SHALL check that the result still equals the operands captured at E0.
REQ-033 With WIDTH=4, the bench SHALL run all 512 combinations of a, b and cin against a behavioural model, checking {cout,sum}=a+b+cin.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width that can represent WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder cell used by the serial adder datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cell_s;
  logic             cell_co;
  logic             last_bit;

  fa_bit u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  assign last_bit = (cnt == LAST_CNT);
  assign res_nxt  = {cell_s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured once at acceptance so later input changes cannot disturb the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          carry  <= cell_co;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= cell_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
